// File: rtl/riscv_core_dpath_muldiv_wb.sv
// Writeback stage for the iterative mul/div unit: in-order destination tag FIFO,
// 64-bit response capture, low/high word select and a single val/rdy output register.
module riscv_core_dpath_muldiv_wb #(
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue_val,
  input  logic          unit_req_rdy,
  output logic          issue_rdy,
  input  logic          issue_sel,
  input  logic [4:0]    issue_waddr,
  input  logic          unit_resp_val,
  input  logic [63:0]   unit_resp_result,
  output logic          unit_resp_rdy,
  output logic          wb_val,
  output logic [4:0]    wb_waddr,
  output logic [31:0]   wb_data,
  input  logic          wb_rdy,
  output logic [CW-1:0] tag_count,
  output logic          err
);

  localparam int PW = $clog2(DEPTH);

  logic          r_tag_sel   [DEPTH];
  logic [4:0]    r_tag_waddr [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_wb_val;
  logic [4:0]    r_wb_waddr;
  logic [31:0]   r_wb_data;
  logic          r_err;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_resp_acc;
  logic          w_pop;
  logic          w_orphan;
  logic          w_head_sel;
  logic [4:0]    w_head_waddr;

  // Full gating uses the current count only; a pop in the same cycle gives no credit.
  assign w_full        = (r_count == CW'(DEPTH));
  assign w_empty       = (r_count == '0);
  assign issue_rdy     = unit_req_rdy & ~w_full;
  assign unit_resp_rdy = ~r_wb_val | wb_rdy;

  assign w_push        = issue_val & issue_rdy;
  assign w_resp_acc    = unit_resp_val & unit_resp_rdy;
  assign w_pop         = w_resp_acc & ~w_empty;
  assign w_orphan      = w_resp_acc & w_empty;

  assign w_head_sel    = r_tag_sel[r_rptr];
  assign w_head_waddr  = r_tag_waddr[r_rptr];

  // Tag storage: payload only, validity is carried by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag_sel[r_wptr]   <= issue_sel;
      r_tag_waddr[r_wptr] <= issue_waddr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_orphan) r_err <= 1'b1;
    end
  end

  // Output register: loads on capture, drains on accept, otherwise holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wb_val   <= 1'b0;
      r_wb_waddr <= '0;
      r_wb_data  <= '0;
    end else if (w_pop) begin
      r_wb_val   <= (w_head_waddr != 5'd0);
      r_wb_waddr <= w_head_waddr;
      r_wb_data  <= w_head_sel ? unit_resp_result[63:32] : unit_resp_result[31:0];
    end else if (r_wb_val & wb_rdy) begin
      r_wb_val   <= 1'b0;
    end
  end

  assign wb_val    = r_wb_val;
  assign wb_waddr  = r_wb_waddr;
  assign wb_data   = r_wb_data;
  assign tag_count = r_count;
  assign err       = r_err;

endmodule

// File: tb/tb_riscv_core_dpath_muldiv_wb.sv
// Bench for riscv_core_dpath_muldiv_wb: directed vector table, async-reset and
// orphan sequences, then randomized traffic against a queue-based reference model.
module tb_riscv_core_dpath_muldiv_wb;

  localparam int DEPTH = 2;
  localparam int CW    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_val, unit_req_rdy, issue_sel, unit_resp_val, wb_rdy;
  logic [4:0]    issue_waddr;
  logic [63:0]   unit_resp_result;
  logic          issue_rdy, unit_resp_rdy, wb_val, err;
  logic [4:0]    wb_waddr;
  logic [31:0]   wb_data;
  logic [CW-1:0] tag_count;

  int n_pass = 0;
  int n_tot  = 0;

  riscv_core_dpath_muldiv_wb #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .issue_val(issue_val), .unit_req_rdy(unit_req_rdy), .issue_rdy(issue_rdy),
    .issue_sel(issue_sel), .issue_waddr(issue_waddr),
    .unit_resp_val(unit_resp_val), .unit_resp_result(unit_resp_result),
    .unit_resp_rdy(unit_resp_rdy),
    .wb_val(wb_val), .wb_waddr(wb_waddr), .wb_data(wb_data), .wb_rdy(wb_rdy),
    .tag_count(tag_count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv, urr, sel;
    logic [4:0]  wa;
    logic        rv;
    logic [63:0] res;
    logic        wrdy;
    logic        e_irdy, e_rrdy;
    logic        e_wbv;
    logic [4:0]  e_wba;
    logic [31:0] e_wbd;
    logic [1:0]  e_cnt;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic       sel;
    logic [4:0] wa;
  } tag_t;

  vec_t vt [19];

  tag_t        mq [$];
  logic        m_wbv, m_err;
  logic [4:0]  m_wba;
  logic [31:0] m_wbd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic drv(input logic iv, input logic urr, input logic sel, input logic [4:0] wa,
                     input logic rv, input logic [63:0] res, input logic wrdy);
    issue_val = iv; unit_req_rdy = urr; issue_sel = sel; issue_waddr = wa;
    unit_resp_val = rv; unit_resp_result = res; wb_rdy = wrdy;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b0;
    drv(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 64'h0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string s;
    s = $sformatf("v%0d", idx);
    @(negedge clk);
    drv(v.iv, v.urr, v.sel, v.wa, v.rv, v.res, v.wrdy);
    #1;
    chk({s, ".issue_rdy"}, 64'(issue_rdy), 64'(v.e_irdy));
    chk({s, ".unit_resp_rdy"}, 64'(unit_resp_rdy), 64'(v.e_rrdy));
    @(posedge clk);
    #1;
    chk({s, ".wb_val"}, 64'(wb_val), 64'(v.e_wbv));
    chk({s, ".wb_waddr"}, 64'(wb_waddr), 64'(v.e_wba));
    chk({s, ".wb_data"}, 64'(wb_data), 64'(v.e_wbd));
    chk({s, ".tag_count"}, 64'(tag_count), 64'(v.e_cnt));
    chk({s, ".err"}, 64'(err), 64'(v.e_err));
  endtask

  initial begin
    //             iv    urr   sel   wa    rv    res                    wrdy  irdy  rrdy  wbv   wba   wbd            cnt   err
    vt[0]  = '{1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 64'h0,                 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,         2'd1, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 64'h00000001_FFFFFFFE, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 32'hFFFFFFFE, 2'd0, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 64'h0,                 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 32'hFFFFFFFE, 2'd0, 1'b0};
    vt[3]  = '{1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 64'h0,                 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 32'hFFFFFFFE, 2'd1, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 64'h00000003_00000002, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h00000003, 2'd0, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 64'hDEADBEEF_CAFEF00D, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h00000003, 2'd0, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 64'hDEADBEEF_CAFEF00D, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h00000003, 2'd0, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 64'h0,                 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h00000003, 2'd0, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 64'h0,                 1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 32'h00000003, 2'd0, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 5'd1, 1'b0, 64'h0,                 1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 32'h00000003, 2'd1, 1'b0};
    vt[10] = '{1'b1, 1'b1, 1'b1, 5'd2, 1'b0, 64'h0,                 1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 32'h00000003, 2'd2, 1'b0};
    vt[11] = '{1'b1, 1'b1, 1'b0, 5'd3, 1'b0, 64'h0,                 1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 32'h00000003, 2'd2, 1'b0};
    vt[12] = '{1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 64'h11111111_22222222, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 32'h22222222, 2'd1, 1'b0};
    vt[13] = '{1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 64'h33333333_44444444, 1'b1, 1'b1, 1'b1, 1'b1, 5'd2, 32'h33333333, 2'd1, 1'b0};
    vt[14] = '{1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 64'h55555555_66666666, 1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 32'h66666666, 2'd0, 1'b0};
    vt[15] = '{1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 64'h0,                 1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 32'h66666666, 2'd1, 1'b0};
    vt[16] = '{1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 64'h77777777_88888888, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h88888888, 2'd0, 1'b0};
    vt[17] = '{1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 64'h99999999_AAAAAAAA, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h88888888, 2'd0, 1'b1};
    vt[18] = '{1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 64'h0,                 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h88888888, 2'd0, 1'b1};

    // Reset held low with random inputs toggling.
    reset = 1'b1;
    drv(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 64'h0, 1'b0);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drv(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom),
          {$urandom, $urandom}, 1'($urandom));
      #1;
      chk("rst.wb_val", 64'(wb_val), 64'h0);
      chk("rst.wb_waddr", 64'(wb_waddr), 64'h0);
      chk("rst.wb_data", 64'(wb_data), 64'h0);
      chk("rst.tag_count", 64'(tag_count), 64'h0);
      chk("rst.err", 64'(err), 64'h0);
    end
    @(negedge clk);
    drv(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 64'h0, 1'b0);
    reset = 1'b1;
    #1;
    chk("rel.wb_val", 64'(wb_val), 64'h0);
    chk("rel.tag_count", 64'(tag_count), 64'h0);

    for (int i = 0; i < 19; i++) run_vec(i, vt[i]);

    // Asynchronous reset between edges while wb_val is high.
    reset_dut();
    @(negedge clk);
    drv(1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 64'h0, 1'b0);
    @(negedge clk);
    drv(1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 64'hABCD0123_00000000, 1'b0);
    @(posedge clk);
    #1;
    chk("ar.pre.wb_val", 64'(wb_val), 64'h1);
    chk("ar.pre.wb_data", 64'(wb_data), 64'hABCD0123);
    drv(1'b1, 1'b1, 1'b0, 5'd3, 1'b0, 64'h0, 1'b0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("ar.wb_val", 64'(wb_val), 64'h0);
    chk("ar.wb_waddr", 64'(wb_waddr), 64'h0);
    chk("ar.wb_data", 64'(wb_data), 64'h0);
    chk("ar.tag_count", 64'(tag_count), 64'h0);
    @(negedge clk);
    drv(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 64'h0, 1'b0);
    reset = 1'b1;

    // Push and response together on an empty FIFO: no bypass, orphan error.
    reset_dut();
    @(negedge clk);
    drv(1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 64'h12345678_9ABCDEF0, 1'b1);
    @(posedge clk);
    #1;
    chk("nb.err", 64'(err), 64'h1);
    chk("nb.tag_count", 64'(tag_count), 64'h1);
    chk("nb.wb_val", 64'(wb_val), 64'h0);

    // Randomized traffic against the reference model.
    reset_dut();
    mq.delete();
    m_wbv = 1'b0; m_wba = '0; m_wbd = '0; m_err = 1'b0;
    for (int c = 0; c < 600; c++) begin
      logic e_irdy, e_rrdy, push, acc;
      tag_t t;
      @(negedge clk);
      drv(($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0), 1'($urandom),
          ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
          ($urandom_range(0, 4) < 2), {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
      #1;
      e_irdy = unit_req_rdy && (mq.size() < DEPTH);
      e_rrdy = !m_wbv || wb_rdy;
      chk("rnd.issue_rdy", 64'(issue_rdy), 64'(e_irdy));
      chk("rnd.unit_resp_rdy", 64'(unit_resp_rdy), 64'(e_rrdy));
      push = issue_val && e_irdy;
      acc  = unit_resp_val && e_rrdy;
      t.sel = issue_sel; t.wa = issue_waddr;
      if (acc && mq.size() > 0) begin
        tag_t h;
        h = mq.pop_front();
        m_wbd = h.sel ? unit_resp_result[63:32] : unit_resp_result[31:0];
        m_wba = h.wa;
        m_wbv = (h.wa != 5'd0);
      end else begin
        if (acc) m_err = 1'b1;
        if (m_wbv && wb_rdy) m_wbv = 1'b0;
      end
      if (push) mq.push_back(t);
      @(posedge clk);
      #1;
      chk("rnd.wb_val", 64'(wb_val), 64'(m_wbv));
      chk("rnd.wb_waddr", 64'(wb_waddr), 64'(m_wba));
      chk("rnd.wb_data", 64'(wb_data), 64'(m_wbd));
      chk("rnd.tag_count", 64'(tag_count), 64'(mq.size()));
      chk("rnd.err", 64'(err), 64'(m_err));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
